// File: rtl/reg_wb_arbiter.sv
// Writeback arbiter: shares the register-file write port between an execute (A) and a load (B) requester,
// registers the winning write, flags reads of the in-flight register, and counts arbitration conflicts.
module reg_wb_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int FIXED_PRIO = 0,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic              reg_we,
  output logic [ADDR_W-1:0] w_addr,
  output logic [DATA_W-1:0] w_data,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic              rs1_pend,
  output logic              rs2_pend,
  output logic [CNT_W-1:0]  conflict_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              r_last;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic [CNT_W-1:0]  r_cnt;

  logic w_conflict;
  logic w_grant_a;
  logic w_grant_b;

  // On a conflict A wins under fixed priority, or when B took the previous conflict.
  assign w_conflict = a_valid && b_valid;
  assign w_grant_a  = a_valid && (!b_valid || (FIXED_PRIO != 0) || r_last);
  assign w_grant_b  = b_valid && !w_grant_a;

  assign a_ready = w_grant_a;
  assign b_ready = w_grant_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last <= 1'b1;
      r_we   <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_conflict) begin
        r_last <= w_grant_b;
        if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CNT_ONE;
      end
      // Writes to x0 are accepted but never reach the register file.
      if (w_grant_a) begin
        r_we   <= (a_addr != '0);
        r_addr <= a_addr;
        r_data <= a_data;
      end else if (w_grant_b) begin
        r_we   <= (b_addr != '0);
        r_addr <= b_addr;
        r_data <= b_data;
      end else begin
        r_we   <= 1'b0;
      end
    end
  end

  assign reg_we       = r_we;
  assign w_addr       = r_addr;
  assign w_data       = r_data;
  assign conflict_cnt = r_cnt;

  assign rs1_pend = r_we && (r_addr == rs1_addr) && (rs1_addr != '0);
  assign rs2_pend = r_we && (r_addr == rs2_addr) && (rs2_addr != '0);

endmodule
